// File: rtl/cpu_mem_responder_pkg.sv
// Shared types for the CPU memory responder: boot FSM states, load-stream beat, saturating counter add.
// No logic of its own; imported by the top, the boot loader and anything that decodes their state.
package cpu_mem_responder_pkg;

  typedef enum logic [1:0] {
    BOOT_IDLE = 2'd0,
    BOOT_LOAD = 2'd1,
    RUN       = 2'd2
  } boot_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } ld_beat_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU-side bus bundle: instruction port, data port, boot-load stream and status outputs.
// Plain wires, no timing; latency and ld_valid/ld_ready backpressure are defined by the responder.
interface cpu_mem_responder_if;

  logic        imem_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;

  logic        dmem_en;
  logic        dmem_wen;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;

  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        boot_skip;

  logic        cpu_reset_n;
  logic        oob_err;
  logic        load_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  modport slave (
    input  imem_en, imem_addr, dmem_en, dmem_wen, dmem_addr, dmem_wdata,
    input  ld_valid, ld_data, ld_last, boot_skip,
    output imem_rdata, dmem_rdata, ld_ready, cpu_reset_n, oob_err, load_err, rd_cnt, wr_cnt
  );

  modport master (
    output imem_en, imem_addr, dmem_en, dmem_wen, dmem_addr, dmem_wdata,
    output ld_valid, ld_data, ld_last, boot_skip,
    input  imem_rdata, dmem_rdata, ld_ready, cpu_reset_n, oob_err, load_err, rd_cnt, wr_cnt
  );

endinterface

// File: rtl/cpu_mem_responder_mem_boot_loader.sv
// Boot FSM and load pointer: turns the ld stream into 32-bit half-word writes, then releases the CPU.
// Beat write is combinational with acceptance; ld_ready is registered, 0 in reset and RUN, 1 while loading.
module mem_boot_loader
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned PTR_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  input  ld_beat_t         ld_beat,
  input  logic             boot_skip,
  output logic             ld_ready,
  output logic             ld_wr_en,
  output logic [PTR_W-1:0] ld_ptr,
  output logic [31:0]      ld_wdata,
  output logic             run,
  output logic             cpu_reset_n,
  output logic             load_err
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  boot_state_t      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rdy_q;
  logic             err_q, err_d;
  logic             cpu_rst_n_q;
  logic             skip;
  logic             accept;
  logic             full;

  // boot_skip wins over a simultaneous beat, so that beat is never written
  assign skip   = (state_q == BOOT_IDLE) && boot_skip;
  assign accept = ld_valid && rdy_q && !skip;
  assign full   = &ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    case (state_q)
      BOOT_IDLE, BOOT_LOAD: begin
        if (skip) begin
          state_d = RUN;
        end else if (accept) begin
          if (ld_beat.last) begin
            state_d = RUN;
          end else if (full) begin
            state_d = RUN;
            err_d   = 1'b1;
          end else begin
            state_d = BOOT_LOAD;
            ptr_d   = ptr_q + PTR_ONE;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT_IDLE;
      ptr_q       <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rdy_q       <= (state_d != RUN);
      err_q       <= err_d;
      cpu_rst_n_q <= (state_d == RUN);
    end
  end

  assign ld_ready    = rdy_q;
  assign ld_wr_en    = accept;
  assign ld_ptr      = ptr_q;
  assign ld_wdata    = ld_beat.data;
  assign run         = (state_q == RUN);
  assign cpu_reset_n = cpu_rst_n_q;
  assign load_err    = err_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Boot-loadable 64-bit memory with instruction/data ports; reads return 1 cycle after request, read-first.
// No backpressure on CPU ports; MEM_PERF_CNT_EN adds saturating read/write counters (else tied to 0).
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic                 clk,
  input logic                 reset,
  cpu_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [63:0] mem [DEPTH_WORDS];

  logic          run;
  logic          ld_wr_en;
  logic [AW:0]   ld_ptr;
  logic [31:0]   ld_wdata;
  ld_beat_t      ld_beat;

  logic [AW-1:0] i_idx, d_idx;
  logic          i_oob, d_oob;
  logic          i_rd, d_rd, d_wr;
  logic [31:0]   imem_q;
  logic [63:0]   dmem_q;
  logic          oob_q;
  logic          unused_addr_bits;

  assign ld_beat = '{data: bus.ld_data, last: bus.ld_last};

  mem_boot_loader #(
    .PTR_W (AW + 1)
  ) u_loader (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (bus.ld_valid),
    .ld_beat     (ld_beat),
    .boot_skip   (bus.boot_skip),
    .ld_ready    (bus.ld_ready),
    .ld_wr_en    (ld_wr_en),
    .ld_ptr      (ld_ptr),
    .ld_wdata    (ld_wdata),
    .run         (run),
    .cpu_reset_n (bus.cpu_reset_n),
    .load_err    (bus.load_err)
  );

  assign i_idx = bus.imem_addr[AW+2:3];
  assign d_idx = bus.dmem_addr[AW+2:3];
  assign i_oob = |bus.imem_addr[63:AW+3];
  assign d_oob = |bus.dmem_addr[63:AW+3];

  // CPU requests only exist in RUN; before that the loader owns the array
  assign i_rd = run && bus.imem_en;
  assign d_rd = run && bus.dmem_en && !bus.dmem_wen;
  assign d_wr = run && bus.dmem_en && bus.dmem_wen;

  assign unused_addr_bits = ^{bus.imem_addr[1:0], bus.dmem_addr[2:0]};

  // Storage has no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (d_wr && !d_oob) begin
      mem[d_idx] <= bus.dmem_wdata;
    end
    if (ld_wr_en) begin
      if (ld_ptr[0]) begin
        mem[ld_ptr[AW:1]][63:32] <= ld_wdata;
      end else begin
        mem[ld_ptr[AW:1]][31:0] <= ld_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_q <= '0;
      dmem_q <= '0;
      oob_q  <= 1'b0;
    end else begin
      if (i_rd) begin
        if (i_oob) begin
          imem_q <= '0;
        end else if (bus.imem_addr[2]) begin
          imem_q <= mem[i_idx][63:32];
        end else begin
          imem_q <= mem[i_idx][31:0];
        end
      end
      if (d_rd) begin
        dmem_q <= d_oob ? '0 : mem[d_idx];
      end
      if ((i_rd && i_oob) || ((d_rd || d_wr) && d_oob)) begin
        oob_q <= 1'b1;
      end
    end
  end

  assign bus.imem_rdata = imem_q;
  assign bus.dmem_rdata = dmem_q;
  assign bus.oob_err    = oob_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  logic [1:0]  rd_inc;

  assign rd_inc = {1'b0, i_rd} + {1'b0, d_rd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= sat_add(rd_cnt_q, rd_inc);
      wr_cnt_q <= sat_add(wr_cnt_q, {1'b0, d_wr});
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`else
  assign bus.rd_cnt = '0;
  assign bus.wr_cnt = '0;
`endif

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 64-bit storage words (power of two).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_en  in  1  instruction read request.
REQ-005 SHALL have port imem_addr  in  64  instruction byte address.
REQ-006 SHALL have port imem_rdata  out  32  instruction read data.
REQ-007 SHALL have port dmem_en  in  1  data access request.
REQ-008 SHALL have port dmem_wen  in  1  data write (1) or read (0), qualified by dmem_en.
REQ-009 SHALL have port dmem_addr  in  64  data byte address.
REQ-010 SHALL have port dmem_wdata  in  64  data write value.
REQ-011 SHALL have port dmem_rdata  out  64  data read value.
REQ-012 SHALL have port ld_valid / ld_ready / ld_data[31:0] / ld_last  in/out/in/in  boot-load stream, one 32-bit instruction per beat.
REQ-013 SHALL have port boot_skip  in  1  bypass loading, go straight to run.
REQ-014 SHALL have port cpu_reset_n  out  1  active-low reset to the CPU, low until run.
REQ-015 SHALL have ports oob_err, load_err  out  1 each  sticky error flags.
REQ-016 SHALL have ports rd_cnt, wr_cnt  out  32 each  access counters.

Function
REQ-017 SHALL map word index = addr[3+log2(DEPTH_WORDS)-1:3]; addr >= DEPTH_WORDS*8 is out-of-range.
REQ-018 SHALL return imem_rdata one cycle after an imem_en edge; addr[2]=0 selects bits [31:0], addr[2]=1 bits [63:32]; held when imem_en=0.
REQ-019 SHALL return dmem_rdata one cycle after a dmem_en&!dmem_wen edge; held otherwise.
REQ-020 SHALL write all 64 bits of dmem_wdata at the edge where dmem_en&dmem_wen; no byte strobes.
REQ-021 SHALL be read-first: a read (either port) of a word written the same cycle returns the old value.
REQ-022 SHALL, on out-of-range access, return 0, drop writes, set oob_err (sticky until reset).
REQ-023 SHALL implement FSM BOOT_IDLE -> BOOT_LOAD on first ld_valid beat; BOOT_IDLE -> RUN on boot_skip; BOOT_LOAD -> RUN on accepted beat with ld_last; RUN terminal until reset.
REQ-024 SHALL drive ld_ready=1 only in BOOT_IDLE/BOOT_LOAD; beat accepted when ld_valid&ld_ready.
REQ-025 SHALL write accepted beats to consecutive 32-bit halves starting at byte 0 (even beat -> [31:0], odd -> [63:32]).
REQ-026 SHALL, when the beat filling the last half (index 2*DEPTH_WORDS-1) lacks ld_last, write it, set load_err, enter RUN.
REQ-027 SHALL ignore imem/dmem requests outside RUN (rdata holds, no write, no counting); cpu_reset_n asserts high the cycle after entering RUN.
REQ-028 SHALL give boot_skip priority over ld_valid when both high in BOOT_IDLE.

Reset
REQ-029 SHALL on reset: FSM=BOOT_IDLE, load pointer=0, imem_rdata=0, dmem_rdata=0, cpu_reset_n=0, ld_ready=0 during reset then 1, oob_err=load_err=0, counters=0; memory contents not reset.
REQ-030 SHALL abort a load mid-stream on reset; restart from pointer 0.

Configuration
REQ-031 SHALL, with MEM_PERF_CNT_EN defined, count accepted RUN-state reads (rd_cnt, both ports; simultaneous reads add 2) and writes (wr_cnt), saturating at 32'hFFFF_FFFF.
REQ-032 SHALL, without MEM_PERF_CNT_EN, tie rd_cnt and wr_cnt to 0 with no counter logic.

Structure
REQ-033 SHALL place FSM state enum (boot_state_t) and load-beat struct in the shared common package.
REQ-034 SHALL use one sub-module, mem_boot_loader, holding the FSM and load pointer; storage array and ports stay in the top.

Verification
REQ-035 Load 3 beats 0x00000013,0x00500093,0x00100113(last) -> word0=0x00500093_00000013, word1[31:0]=0x00100113, cpu_reset_n=1 next cycle.
REQ-036 RUN, dmem write 0xDEADBEEF_CAFEF00D @0x10 then read @0x10 -> dmem_rdata=0xDEADBEEF_CAFEF00D one cycle after read; imem @0x14 -> 0xDEADBEEF.
REQ-037 Same-cycle dmem write 0x1 and imem/dmem read @0x18 holding 0x0 -> both reads return 0x0; next read -> 0x1.
REQ-038 DEPTH_WORDS=4, dmem write @0x20 -> no write, dmem_rdata on read=0, oob_err=1 until reset.
REQ-039 DEPTH_WORDS=4, 8 beats no ld_last -> load_err=1, RUN entered; reset asserted mid-load (beat 2) -> BOOT_IDLE, pointer 0.
REQ-040 MEM_PERF_CNT_EN: 5 reads, 3 writes, 1 simultaneous imem+dmem read -> rd_cnt=7, wr_cnt=3; without macro both 0.
